// File: rtl/debug_loader_if.sv
// Host debug port bundle between debug_loader_unit and the UART/MIPS side.
// master: the loader's view; slave: the UART/CPU/memory side.
interface debug_loader_if #(
  parameter int unsigned len_data = 32,
  parameter int unsigned len_addr = 8
);
  logic [7:0]          rx_data;
  logic                rx_done;
  logic                tx_done;
  logic                halt_flag;
  logic [len_addr-1:0] in_pc;
  logic                debug_flag;
  logic [len_addr-1:0] in_addr_mem_inst;
  logic [len_data-1:0] in_ins_to_mem;
  logic                wea_ram_inst;
  logic                cpu_enable;
  logic [7:0]          tx_data;
  logic                tx_start;

  modport master (
    input  rx_data, rx_done, tx_done, halt_flag, in_pc,
    output debug_flag, in_addr_mem_inst, in_ins_to_mem, wea_ram_inst,
           cpu_enable, tx_data, tx_start
  );

  modport slave (
    output rx_data, rx_done, tx_done, halt_flag, in_pc,
    input  debug_flag, in_addr_mem_inst, in_ins_to_mem, wea_ram_inst,
           cpu_enable, tx_data, tx_start
  );
endinterface

// File: rtl/debug_loader_unit.sv
// Debug loader: assembles UART bytes into instruction words, runs/steps the pipeline, reports PC.
// Optional macro DEBUG_LOADER_CYCLE_COUNT_EN appends a 32-bit enabled-cycle count after the PC byte.
module debug_loader_unit #(
  parameter int unsigned         len_data  = 32,
  parameter int unsigned         len_addr  = 8,
  parameter logic [len_data-1:0] HALT_WORD = len_data'(32'hFFFF_FFFF),
  parameter logic [7:0]          CMD_LOAD  = 8'h01,
  parameter logic [7:0]          CMD_RUN   = 8'h02,
  parameter logic [7:0]          CMD_STEP  = 8'h03
) (
  input logic             clk,
  input logic             reset,
  debug_loader_if.master  bus
);

  localparam int unsigned         NBYTES   = len_data / 8;
  localparam int unsigned         BCNT_W   = $clog2(NBYTES + 1);
  localparam logic [len_addr-1:0] ADDR_MAX = {len_addr{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_STEP,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [len_data-1:0] word_q, word_d;
  logic [len_addr-1:0] addr_q, addr_d;
  logic                debug_q, debug_d;
  logic                wea_q, wea_d;
  logic                cpu_en_q, cpu_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;

`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
  localparam logic [2:0] TX_LAST = 3'd4;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_byte_c;

  // Byte 0 is the PC, bytes 1..4 the cycle count MSB first.
  always_comb begin
    tx_byte_c = 8'(bus.in_pc);
    case (tx_idx_q)
      3'd1:    tx_byte_c = cyc_cnt_q[31:24];
      3'd2:    tx_byte_c = cyc_cnt_q[23:16];
      3'd3:    tx_byte_c = cyc_cnt_q[15:8];
      3'd4:    tx_byte_c = cyc_cnt_q[7:0];
      default: tx_byte_c = 8'(bus.in_pc);
    endcase
  end
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      debug_q    <= 1'b0;
      wea_q      <= 1'b0;
      cpu_en_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
      cyc_cnt_q  <= '0;
      tx_idx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      debug_q    <= debug_d;
      wea_q      <= wea_d;
      cpu_en_q   <= cpu_en_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
      cyc_cnt_q  <= cyc_cnt_d;
      tx_idx_q   <= tx_idx_d;
`endif
    end
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    debug_d    = debug_q;
    wea_d      = 1'b0;
    cpu_en_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
    cyc_cnt_d  = cpu_en_q ? cyc_cnt_q + 32'd1 : cyc_cnt_q;
    tx_idx_d   = tx_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.rx_done) begin
          if (bus.rx_data == CMD_LOAD) begin
            state_d    = S_LOAD;
            debug_d    = 1'b1;
            addr_d     = '0;
            byte_cnt_d = '0;
            word_d     = '0;
          end else if (bus.rx_data == CMD_RUN) begin
            state_d  = S_RUN;
            // A halt already pending means the pipeline is never enabled.
            cpu_en_d = ~bus.halt_flag;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
            cyc_cnt_d = '0;
            tx_idx_d  = '0;
`endif
          end else if (bus.rx_data == CMD_STEP) begin
            state_d  = S_STEP;
            cpu_en_d = 1'b1;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
            cyc_cnt_d = '0;
            tx_idx_d  = '0;
`endif
          end
        end
      end

      S_LOAD: begin
        if (bus.rx_done) begin
          word_d = {word_q[len_data-9:0], bus.rx_data};
          if (byte_cnt_q == BCNT_W'(NBYTES - 1)) begin
            state_d    = S_WRITE;
            wea_d      = 1'b1;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        // Write strobe is high this cycle; the halt word itself is stored.
        if ((word_q == HALT_WORD) || (addr_q == ADDR_MAX)) begin
          state_d = S_IDLE;
          debug_d = 1'b0;
          addr_d  = '0;
        end else begin
          state_d = S_LOAD;
          addr_d  = addr_q + len_addr'(1);
        end
      end

      S_RUN: begin
        if (bus.halt_flag) begin
          state_d = S_SEND;
        end else begin
          cpu_en_d = 1'b1;
        end
      end

      S_STEP: begin
        state_d = S_SEND;
      end

      S_SEND: begin
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TX;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
        tx_data_d  = tx_byte_c;
`else
        tx_data_d  = 8'(bus.in_pc);
`endif
      end

      S_WAIT_TX: begin
        if (bus.tx_done) begin
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
          if (tx_idx_q == TX_LAST) begin
            state_d  = S_IDLE;
            tx_idx_d = '0;
          end else begin
            state_d  = S_SEND;
            tx_idx_d = tx_idx_q + 3'd1;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.debug_flag       = debug_q;
  assign bus.in_addr_mem_inst = addr_q;
  assign bus.in_ins_to_mem    = word_q;
  assign bus.wea_ram_inst     = wea_q;
  assign bus.cpu_enable       = cpu_en_q;
  assign bus.tx_data          = tx_data_q;
  assign bus.tx_start         = tx_start_q;

endmodule

// File: tb/tb_debug_loader_unit.sv
// Self-checking bench for debug_loader_unit: vector table, directed corner sequences,
// and randomized commands checked against a word/command level reference model.
module tb_debug_loader_unit;

  localparam logic [7:0]  C_LOAD = 8'h01;
  localparam logic [7:0]  C_RUN  = 8'h02;
  localparam logic [7:0]  C_STEP = 8'h03;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
`ifdef DEBUG_LOADER_CYCLE_COUNT_EN
  localparam int NEXTRA = 4;
`else
  localparam int NEXTRA = 0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          kind;      // 1 load, 2 run, 3 step
    logic [31:0] w0, w1, w2;
    int          nw;
    int          h;         // enabled cycles after which the CPU raises halt (0 = already halted)
    logic [7:0]  base, inc; // PC = base + inc * enabled cycles
    int          exp_nwr;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic [7:0]  al;
    logic [31:0] dl;
    int          exp_en;
    logic [7:0]  exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  debug_loader_if #(.len_data(32), .len_addr(8)) bus ();

  debug_loader_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int inv_errs = 0;
  int en_cnt = 0;
  int en_base = 0;
  int tx_cd = 0;
  int halt_after = 0;
  logic halt_arm = 1'b0;
  logic [7:0] pc_base = 8'h00;
  logic [7:0] pc_inc = 8'h00;
  wr_t got_wr[$];
  logic [7:0] got_tx[$];

  // Minimal CPU/UART models: PC advances per enabled cycle, halt after a set count, tx_done 3 cycles after tx_start.
  always @(posedge clk) if (bus.cpu_enable) en_cnt <= en_cnt + 1;
  always @(posedge clk) begin
    if (bus.tx_start) tx_cd <= 3;
    else if (tx_cd != 0) tx_cd <= tx_cd - 1;
  end
  assign bus.tx_done   = (tx_cd == 1);
  assign bus.halt_flag = halt_arm && ((en_cnt - en_base) >= halt_after);
  assign bus.in_pc     = 8'(int'(pc_base) + int'(pc_inc) * (en_cnt - en_base));

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wea_ram_inst) got_wr.push_back('{bus.in_addr_mem_inst, bus.in_ins_to_mem});
      if (bus.tx_start) got_tx.push_back(bus.tx_data);
      if (bus.debug_flag && bus.cpu_enable) inv_errs <= inv_errs + 1;
      if (bus.wea_ram_inst && !bus.debug_flag) inv_errs <= inv_errs + 1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic load_words(input logic [31:0] ws[$]);
    send_byte(C_LOAD);
    foreach (ws[i])
      for (int k = 3; k >= 0; k--) send_byte(8'(ws[i] >> (8 * k)));
    repeat (4) tick();
  endtask

  // Reference: words land at consecutive addresses from 0; load ends at HALT or the top address.
  function automatic void model_load(input logic [31:0] ws[$], output wr_t ex[$]);
    int addr = 0;
    ex = {};
    foreach (ws[i]) begin
      ex.push_back('{8'(addr), ws[i]});
      if (ws[i] == HALT || addr == 255) break;
      addr++;
    end
  endfunction

  // Reference: RUN enables until the cycle after halt is seen (none if already halted); STEP enables once.
  function automatic int model_en(input int kind, input int h);
    if (kind == 3) return 1;
    return (h == 0) ? 0 : h + 1;
  endfunction

  task automatic check_load(input string tag, input wr_t ex[$], input int wr0);
    check({tag, " nwrites"}, 32'(got_wr.size() - wr0), 32'(ex.size()));
    foreach (ex[i])
      if (wr0 + i < got_wr.size()) begin
        check({tag, " waddr"}, 32'(got_wr[wr0 + i].a), 32'(ex[i].a));
        check({tag, " wdata"}, got_wr[wr0 + i].d, ex[i].d);
      end
    check({tag, " debug_flag_after"}, 32'(bus.debug_flag), 32'd0);
    check({tag, " addr_after"}, 32'(bus.in_addr_mem_inst), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input int kind, input int h,
                         input logic [7:0] base, input logic [7:0] inc,
                         input int exp_en, input logic [7:0] exp_pc);
    int tx0 = got_tx.size();
    int wr0 = got_wr.size();
    logic [31:0] cnt;
    halt_arm   = (kind == 2);
    halt_after = h;
    pc_base    = base;
    pc_inc     = inc;
    en_base    = en_cnt;
    send_byte(kind == 2 ? C_RUN : C_STEP);
    for (int k = 0; k < 600 && got_tx.size() < tx0 + 1 + NEXTRA; k++) tick();
    repeat (6) tick();
    check({tag, " cpu_enable_cycles"}, 32'(en_cnt - en_base), 32'(exp_en));
    check({tag, " tx_count"}, 32'(got_tx.size() - tx0), 32'(1 + NEXTRA));
    check({tag, " no_writes"}, 32'(got_wr.size() - wr0), 32'd0);
    if (got_tx.size() > tx0) check({tag, " tx_pc"}, 32'(got_tx[tx0]), 32'(exp_pc));
    cnt = 32'(exp_en);
    for (int i = 1; i <= NEXTRA; i++)
      if (got_tx.size() > tx0 + i)
        check({tag, " tx_count_byte"}, 32'(got_tx[tx0 + i]), 32'(8'(cnt >> (8 * (4 - i)))));
    halt_arm = 1'b0;
  endtask

  vec_t tab[6];

  initial begin
    logic [31:0] ws[$];
    wr_t ex[$];
    int wr0;

    tab[0] = '{1, 32'h12345678, HALT, 32'h0, 2, 0, 8'h00, 8'h00, 2, 8'h00, 32'h12345678, 8'h01, HALT, 0, 8'h00};
    tab[1] = '{2, 32'h0, 32'h0, 32'h0, 0, 9, 8'h00, 8'h01, 0, 8'h00, 32'h0, 8'h00, 32'h0, 10, 8'h0A};
    tab[2] = '{3, 32'h0, 32'h0, 32'h0, 0, 0, 8'h00, 8'h04, 0, 8'h00, 32'h0, 8'h00, 32'h0, 1, 8'h04};
    tab[3] = '{2, 32'h0, 32'h0, 32'h0, 0, 0, 8'h33, 8'h05, 0, 8'h00, 32'h0, 8'h00, 32'h0, 0, 8'h33};
    tab[4] = '{1, 32'hDEADBEEF, 32'h00000007, HALT, 3, 0, 8'h00, 8'h00, 3, 8'h00, 32'hDEADBEEF, 8'h02, HALT, 0, 8'h00};
    tab[5] = '{2, 32'h0, 32'h0, 32'h0, 0, 1, 8'h10, 8'h02, 0, 8'h00, 32'h0, 8'h00, 32'h0, 2, 8'h14};

    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset debug_flag", 32'(bus.debug_flag), 32'd0);
    check("reset addr", 32'(bus.in_addr_mem_inst), 32'd0);
    check("reset data", bus.in_ins_to_mem, 32'd0);
    check("reset wea", 32'(bus.wea_ram_inst), 32'd0);
    check("reset cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check("reset tx_data", 32'(bus.tx_data), 32'd0);
    check("reset tx_start", 32'(bus.tx_start), 32'd0);

    // Unknown command byte in IDLE: outputs stay at their reset values.
    send_byte(8'h7E);
    for (int i = 0; i < 20; i++) begin
      check("idle_unknown_cmd quiet",
            32'({bus.debug_flag, bus.in_addr_mem_inst, bus.wea_ram_inst, bus.cpu_enable,
                 bus.tx_data, bus.tx_start}) | bus.in_ins_to_mem, 32'd0);
      tick();
    end
    run_cmd("step_after_unknown", 3, 0, 8'h20, 8'h04, 1, 8'h24);

    foreach (tab[i]) begin
      if (tab[i].kind == 1) begin
        wr0 = got_wr.size();
        ws = {};
        if (tab[i].nw > 0) ws.push_back(tab[i].w0);
        if (tab[i].nw > 1) ws.push_back(tab[i].w1);
        if (tab[i].nw > 2) ws.push_back(tab[i].w2);
        load_words(ws);
        check("vec nwrites", 32'(got_wr.size() - wr0), 32'(tab[i].exp_nwr));
        if (got_wr.size() > wr0) begin
          check("vec first addr", 32'(got_wr[wr0].a), 32'(tab[i].a0));
          check("vec first data", got_wr[wr0].d, tab[i].d0);
          check("vec last addr", 32'(got_wr[got_wr.size() - 1].a), 32'(tab[i].al));
          check("vec last data", got_wr[got_wr.size() - 1].d, tab[i].dl);
        end
        check("vec debug_flag_after", 32'(bus.debug_flag), 32'd0);
        check("vec addr_after", 32'(bus.in_addr_mem_inst), 32'd0);
      end else begin
        run_cmd("vec cmd", tab[i].kind, tab[i].h, tab[i].base, tab[i].inc,
                tab[i].exp_en, tab[i].exp_pc);
      end
    end

    // Reset in the middle of a load discards the partial word.
    wr0 = got_wr.size();
    send_byte(C_LOAD);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("midload_reset no_write", 32'(got_wr.size() - wr0), 32'd0);
    check("midload_reset debug_flag", 32'(bus.debug_flag), 32'd0);
    ws = {32'h00000001, HALT};
    model_load(ws, ex);
    load_words(ws);
    check_load("after_reset_load", ex, wr0);

    // Fill the whole memory without a halt word: load stops after the top address.
    ws = {};
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w = $urandom;
      if (w == HALT) w = 32'h0;
      ws.push_back(w);
    end
    wr0 = got_wr.size();
    model_load(ws, ex);
    load_words(ws);
    check_load("full_memory", ex, wr0);

    for (int it = 0; it < 30; it++) begin
      int kind = int'($urandom_range(1, 3));
      if (kind == 1) begin
        int n = int'($urandom_range(0, 4));
        ws = {};
        for (int i = 0; i < n; i++) begin
          logic [31:0] w = $urandom;
          if (w == HALT) w = 32'h1;
          ws.push_back(w);
        end
        ws.push_back(HALT);
        wr0 = got_wr.size();
        model_load(ws, ex);
        load_words(ws);
        check_load("rand_load", ex, wr0);
      end else begin
        int h = int'($urandom_range(0, 15));
        logic [7:0] b = 8'($urandom);
        logic [7:0] s = 8'($urandom);
        int e = model_en(kind, h);
        run_cmd(kind == 2 ? "rand_run" : "rand_step", kind, h, b, s, e,
                8'(int'(b) + int'(s) * e));
      end
    end

    check("debug_flag/cpu_enable exclusive and wea inside load", 32'(inv_errs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
